// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts synchronized rising edges of sig_in
// over GATE_CYCLES clk cycles and reports the count scaled to hertz.
module freq_meter #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] freq_hertz,
  output logic             valid,
  output logic             overflow
);

  localparam int SCALE = CLOCK_FREQ / GATE_CYCLES;
  localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0]    SCALE_W   = PW'(SCALE);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [PW-1:0]    RES_MAX   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic [GW-1:0]    gate_cnt_r;
  logic [GW-1:0]    gate_cnt_s;
  logic [WIDTH-1:0] edge_cnt_r;
  logic [WIDTH-1:0] edge_cnt_s;
  logic [WIDTH-1:0] freq_s;
  logic             ovf_s;
  logic             valid_s;
  logic             edge_s;
  logic             win_end_s;
  logic [PW-1:0]    sum_s;
  logic [PW-1:0]    result_s;

  assign edge_s    = sync2_r & ~prev_r;
  assign win_end_s = (state_r == GATE) && (gate_cnt_r == GATE_LAST);
  // The edge detected on the window-end cycle still belongs to this window.
  assign sum_s     = {{WIDTH{1'b0}}, edge_cnt_r} + PW'(edge_s);
  assign result_s  = sum_s * SCALE_W;

  // Input synchronizer and edge history, free-running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a window end with enable low still reports before leaving GATE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_s = GATE;
        else        state_s = IDLE;
      end
      GATE: begin
        if (enable) state_s = GATE;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Counter and report next values; windows restart back-to-back at window end.
  always_comb begin
    gate_cnt_s = {GW{1'b0}};
    edge_cnt_s = {WIDTH{1'b0}};
    freq_s     = freq_hertz;
    ovf_s      = overflow;
    valid_s    = 1'b0;
    case (state_r)
      GATE: begin
        if (!win_end_s && enable) begin
          gate_cnt_s = gate_cnt_r + GW'(1);
          if (edge_s && (edge_cnt_r != CNT_MAX)) edge_cnt_s = edge_cnt_r + WIDTH'(1);
          else                                   edge_cnt_s = edge_cnt_r;
        end else begin
          gate_cnt_s = {GW{1'b0}};
          edge_cnt_s = {WIDTH{1'b0}};
        end
      end
      IDLE: begin
        gate_cnt_s = {GW{1'b0}};
        edge_cnt_s = {WIDTH{1'b0}};
      end
      default: begin
        gate_cnt_s = {GW{1'b0}};
        edge_cnt_s = {WIDTH{1'b0}};
      end
    endcase
    if (win_end_s) begin
      valid_s = 1'b1;
      if (result_s > RES_MAX) begin
        freq_s = CNT_MAX;
        ovf_s  = 1'b1;
      end else begin
        freq_s = result_s[WIDTH-1:0];
        ovf_s  = 1'b0;
      end
    end else begin
      valid_s = 1'b0;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_r <= {GW{1'b0}};
      edge_cnt_r <= {WIDTH{1'b0}};
      freq_hertz <= {WIDTH{1'b0}};
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      gate_cnt_r <= gate_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      freq_hertz <= freq_s;
      overflow   <= ovf_s;
      valid      <= valid_s;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with CLOCK_FREQ=2000, GATE_CYCLES=100, WIDTH=8
// (20 Hz per edge): table of input periods plus multi-cycle corner sequences.
module tb_freq_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sig_in;
  logic [7:0] freq_hertz;
  logic       valid;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int gen_hi = 0;
  int gen_lo = 0;
  int n;
  int pulses;
  bit seen;

  typedef struct {
    int         hi;
    int         lo;
    logic [7:0] exp_f;
    logic       exp_o;
    string      name;
  } vec_t;

  vec_t vecs[8];

  freq_meter #(
    .CLOCK_FREQ (2000),
    .GATE_CYCLES(100),
    .WIDTH      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sig_in    (sig_in),
    .freq_hertz(freq_hertz),
    .valid     (valid),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // sig_in pattern generator: hi==0 holds low, lo==0 holds high; random phase on change.
  initial begin
    int ph;
    int last_hi;
    int last_lo;
    ph = 0;
    last_hi = -1;
    last_lo = -1;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_hi != last_hi || gen_lo != last_lo) begin
        ph = $urandom_range(0, 99);
        last_hi = gen_hi;
        last_lo = gen_lo;
      end
      if (gen_hi == 0) begin
        sig_in = 1'b0;
      end else if (gen_lo == 0) begin
        sig_in = 1'b1;
      end else begin
        ph = ph % (gen_hi + gen_lo);
        sig_in = (ph < gen_hi) ? 1'b1 : 1'b0;
        ph = ph + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cnt, output bit hit);
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
      if (valid === 1'b1) hit = 1'b1;
    end
  endtask

  task automatic run_quiet(input int cycles, output int p);
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) p++;
    end
  endtask

  initial begin
    vecs[0] = '{hi: 3,  lo: 2,  exp_f: 8'd255, exp_o: 1'b1, name: "p5_sat"};
    vecs[1] = '{hi: 5,  lo: 5,  exp_f: 8'd200, exp_o: 1'b0, name: "p10_after_sat"};
    vecs[2] = '{hi: 0,  lo: 1,  exp_f: 8'd0,   exp_o: 1'b0, name: "held0"};
    vecs[3] = '{hi: 1,  lo: 0,  exp_f: 8'd0,   exp_o: 1'b0, name: "held1"};
    vecs[4] = '{hi: 2,  lo: 2,  exp_f: 8'd255, exp_o: 1'b1, name: "p4_sat"};
    vecs[5] = '{hi: 13, lo: 12, exp_f: 8'd80,  exp_o: 1'b0, name: "p25"};
    vecs[6] = '{hi: 50, lo: 50, exp_f: 8'd20,  exp_o: 1'b0, name: "p100"};
    vecs[7] = '{hi: 10, lo: 10, exp_f: 8'd100, exp_o: 1'b0, name: "p20"};

    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_freq", freq_hertz, 0);
    chk("reset_valid", valid, 0);
    chk("reset_ovf", overflow, 0);

    // Basic period 10: first report 101 cycles after enable is sampled, then every 100.
    @(negedge clk);
    rst_n  = 1'b1;
    gen_hi = 5;
    gen_lo = 5;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    wait_valid(300, n, seen);
    chk("basic_seen", seen, 1);
    chk("basic_first_lat", n, 101);
    chk("basic_freq", freq_hertz, 200);
    chk("basic_ovf", overflow, 0);
    for (int j = 0; j < 2; j++) begin
      wait_valid(300, n, seen);
      chk("basic_seen_n", seen, 1);
      chk("basic_spacing", n, 100);
      chk("basic_freq_n", freq_hertz, 200);
      chk("basic_ovf_n", overflow, 0);
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gen_hi = vecs[i].hi;
      gen_lo = vecs[i].lo;
      repeat (5) @(negedge clk);
      wait_valid(300, n, seen);
      chk($sformatf("%s_settle_seen", vecs[i].name), seen, 1);
      for (int j = 0; j < 2; j++) begin
        wait_valid(300, n, seen);
        chk($sformatf("%s_seen", vecs[i].name), seen, 1);
        chk($sformatf("%s_spacing", vecs[i].name), n, 100);
        chk($sformatf("%s_freq", vecs[i].name), freq_hertz, vecs[i].exp_f);
        chk($sformatf("%s_ovf", vecs[i].name), overflow, vecs[i].exp_o);
      end
    end

    // Mid-window abort: 60 cycles enabled then 20 disabled, result of 100 must hold.
    @(negedge clk);
    enable = 1'b0;
    run_quiet(10, pulses);
    chk("idle_quiet", pulses, 0);
    @(negedge clk);
    enable = 1'b1;
    run_quiet(60, pulses);
    chk("abort_high_quiet", pulses, 0);
    @(negedge clk);
    enable = 1'b0;
    run_quiet(20, pulses);
    chk("abort_low_quiet", pulses, 0);
    chk("abort_hold_freq", freq_hertz, 100);
    chk("abort_hold_ovf", overflow, 0);
    @(negedge clk);
    enable = 1'b1;
    wait_valid(300, n, seen);
    chk("reenable_seen", seen, 1);
    chk("reenable_lat", n, 101);
    chk("reenable_freq", freq_hertz, 100);

    // Reset at gate cycle 50, then a fresh window after release.
    @(negedge clk);
    gen_hi = 5;
    gen_lo = 5;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    run_quiet(50, pulses);
    chk("prereset_quiet", pulses, 0);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("rst_mid_freq", freq_hertz, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_ovf", overflow, 0);
    run_quiet(10, pulses);
    chk("rst_low_quiet", pulses, 0);
    chk("rst_low_freq", freq_hertz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_valid(300, n, seen);
    chk("post_rst_seen", seen, 1);
    chk("post_rst_lat", n, 101);
    chk("post_rst_freq", freq_hertz, 200);
    chk("post_rst_ovf", overflow, 0);

    // enable drops exactly on the window-end cycle: one report, then idle.
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    run_quiet(100, pulses);
    chk("wend_pre_quiet", pulses, 0);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("wend_valid", valid, 1);
    chk("wend_freq", freq_hertz, 200);
    chk("wend_ovf", overflow, 0);
    run_quiet(250, pulses);
    chk("wend_idle_quiet", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
